// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module  : instr_encoder_if
// Purpose : Field-input and instruction-word handshake bundle of instr_encoder
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_oper;
  logic [4:0]  in_rdst;
  logic [4:0]  in_rsrc1;
  logic        in_imm_mode;
  logic [4:0]  in_rsrc2;
  logic [15:0] in_imm;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_out;

  // Host side: supplies fields and consumes instruction words.
  modport master (
    output in_valid, in_oper, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm,
    output ir_ready,
    input  in_ready, ir_valid, ir_out
  );

  modport slave (
    input  in_valid, in_oper, in_rdst, in_rsrc1, in_imm_mode, in_rsrc2, in_imm,
    input  ir_ready,
    output in_ready, ir_valid, ir_out
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Purpose : Checks opcodes, packs legal instructions into IR words, buffers
//           them in a FIFO and issues them over a valid/ready handshake.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int         DEPTH    = 4,
  parameter logic [4:0] MAX_OPER = 5'd4
) (
  input  wire                      clk,
  input  wire                      sys_rst,
  input  wire                      flush,
  instr_encoder_if.slave           bus,
  output logic                     illegal_op,
  output logic [7:0]               illegal_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [4:0] C_OP_MOVSGPR = 5'd0;

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             illegal_op_q, illegal_op_d;
  logic [7:0]       illegal_cnt_q, illegal_cnt_d;

  logic        full_w;
  logic        accept_w;
  logic        legal_w;
  logic        push_w;
  logic        pop_w;
  logic [31:0] word_w;

  assign full_w   = (level_q == LVL_W'(DEPTH));
  assign legal_w  = (bus.in_oper <= MAX_OPER);
  assign accept_w = bus.in_valid && bus.in_ready;
  assign push_w   = accept_w && legal_w;
  assign pop_w    = bus.ir_valid && bus.ir_ready;

  assign bus.in_ready = !full_w && !sys_rst;
  assign bus.ir_valid = (level_q != '0);
  assign bus.ir_out   = bus.ir_valid ? mem_q[rd_ptr_q] : 32'h0;

  assign illegal_op  = illegal_op_q;
  assign illegal_cnt = illegal_cnt_q;
  assign fifo_level  = level_q;

  // movsgpr carries only a destination; every other opcode carries rsrc1 and
  // either a 16-bit immediate or rsrc2 with the low 11 bits zero.
  always_comb begin
    word_w        = 32'h0;
    word_w[31:27] = bus.in_oper;
    word_w[26:22] = bus.in_rdst;
    if (bus.in_oper != C_OP_MOVSGPR) begin
      word_w[21:17] = bus.in_rsrc1;
      word_w[16]    = bus.in_imm_mode;
      if (bus.in_imm_mode) begin
        word_w[15:0] = bus.in_imm;
      end else begin
        word_w[15:11] = bus.in_rsrc2;
      end
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    illegal_op_d  = accept_w && !legal_w;
    illegal_cnt_d = illegal_cnt_q;
    if (accept_w && !legal_w && (illegal_cnt_q != 8'hFF)) begin
      illegal_cnt_d = illegal_cnt_q + 8'd1;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_w && !pop_w) level_d = level_q + LVL_W'(1);
      else if (pop_w && !push_w) level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      illegal_op_q  <= 1'b0;
      illegal_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      illegal_op_q  <= illegal_op_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // Storage needs no reset: level_q gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (push_w && !flush) begin
      mem_q[wr_ptr_q] <= word_w;
    end
  end

endmodule

`default_nettype wire
